// File: rtl/regfile_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : regfile_write_arbiter
// Description : Round-robin arbiter for the register-file write port, with a
//               registered output stage and a busy-bit hazard scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_write_arbiter #(
  parameter int  WIDTH      = 16,
  parameter int  SIZE       = 8,
  parameter int  NREQ       = 2,
  localparam int ADDR_WIDTH = $clog2(SIZE)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NREQ-1:0]            req_valid,
  output logic [NREQ-1:0]            req_ready,
  input  logic [NREQ*ADDR_WIDTH-1:0] req_num,
  input  logic [NREQ*WIDTH-1:0]      req_data,
  input  logic                       hold,
  input  logic                       reserve_valid,
  input  logic [ADDR_WIDTH-1:0]      reserve_num,
  input  logic [ADDR_WIDTH-1:0]      readnum1,
  input  logic [ADDR_WIDTH-1:0]      readnum2,
  output logic                       hazard1,
  output logic                       hazard2,
  output logic                       rf_write,
  output logic [ADDR_WIDTH-1:0]      rf_writenum,
  output logic [WIDTH-1:0]           rf_data_in,
  output logic [SIZE-1:0]            busy
);

  localparam int PTR_WIDTH = $clog2(NREQ);

  logic [PTR_WIDTH-1:0]  ptr_q, ptr_d;
  logic                  rf_write_q, rf_write_d;
  logic [ADDR_WIDTH-1:0] rf_writenum_q, rf_writenum_d;
  logic [WIDTH-1:0]      rf_data_q, rf_data_d;
  logic [SIZE-1:0]       busy_q, busy_d;

  logic [NREQ-1:0]       grant;
  logic                  grant_any;
  logic [PTR_WIDTH-1:0]  grant_idx;
  logic [ADDR_WIDTH-1:0] grant_num;
  logic [WIDTH-1:0]      grant_data;

  logic [SIZE-1:0]       clr_vec;
  logic [SIZE-1:0]       set_vec;
  logic [SIZE-1:0]       rd1_match;
  logic [SIZE-1:0]       rd2_match;

  // Scan requesters starting at ptr; first valid one wins.
  always_comb begin : arb
    int idx;
    grant      = '0;
    grant_any  = 1'b0;
    grant_idx  = '0;
    grant_num  = '0;
    grant_data = '0;
    idx        = 0;
    if (!reset && !hold) begin
      for (int k = 0; k < NREQ; k++) begin
        idx = int'(ptr_q) + k;
        if (idx >= NREQ) idx = idx - NREQ;
        if (!grant_any && req_valid[idx]) begin
          grant_any   = 1'b1;
          grant[idx]  = 1'b1;
          grant_idx   = PTR_WIDTH'(idx);
          grant_num   = req_num[idx*ADDR_WIDTH +: ADDR_WIDTH];
          grant_data  = req_data[idx*WIDTH +: WIDTH];
        end
      end
    end
  end

  assign req_ready = grant;

  always_comb begin
    ptr_d = ptr_q;
    if (grant_any) begin
      ptr_d = (grant_idx == PTR_WIDTH'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

  // Output stage drains every cycle; address/data hold when idle.
  always_comb begin
    rf_write_d    = grant_any;
    rf_writenum_d = rf_writenum_q;
    rf_data_d     = rf_data_q;
    if (grant_any) begin
      rf_writenum_d = grant_num;
      rf_data_d     = grant_data;
    end
  end

  genvar r;
  generate
    for (r = 0; r < SIZE; r++) begin : g_reg
      assign clr_vec[r]   = rf_write_q && (rf_writenum_q == ADDR_WIDTH'(r));
      assign set_vec[r]   = reserve_valid && (reserve_num == ADDR_WIDTH'(r));
      assign rd1_match[r] = (readnum1 == ADDR_WIDTH'(r));
      assign rd2_match[r] = (readnum2 == ADDR_WIDTH'(r));
    end
  endgenerate

  // Set after clear, so a same-cycle reservation keeps the register busy.
  always_comb begin
    busy_d = (busy_q & ~clr_vec) | set_vec;
  end

  assign hazard1 = |(rd1_match & busy_q);
  assign hazard2 = |(rd2_match & busy_q);

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q         <= '0;
      rf_write_q    <= 1'b0;
      rf_writenum_q <= '0;
      rf_data_q     <= '0;
      busy_q        <= '0;
    end else begin
      ptr_q         <= ptr_d;
      rf_write_q    <= rf_write_d;
      rf_writenum_q <= rf_writenum_d;
      rf_data_q     <= rf_data_d;
      busy_q        <= busy_d;
    end
  end

  assign rf_write    = rf_write_q;
  assign rf_writenum = rf_writenum_q;
  assign rf_data_in  = rf_data_q;
  assign busy        = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_regfile_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_regfile_write_arbiter
// Description : Directed and randomized bench with a behavioural reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_write_arbiter;
  localparam int WIDTH = 16;
  localparam int SIZE  = 8;
  localparam int NREQ  = 2;
  localparam int AW    = $clog2(SIZE);

  logic                 clk = 1'b0;
  logic                 reset;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ*AW-1:0]   req_num;
  logic [NREQ*WIDTH-1:0] req_data;
  logic                 hold;
  logic                 reserve_valid;
  logic [AW-1:0]        reserve_num;
  logic [AW-1:0]        readnum1;
  logic [AW-1:0]        readnum2;
  logic                 hazard1;
  logic                 hazard2;
  logic                 rf_write;
  logic [AW-1:0]        rf_writenum;
  logic [WIDTH-1:0]     rf_data_in;
  logic [SIZE-1:0]      busy;

  regfile_write_arbiter #(.WIDTH(WIDTH), .SIZE(SIZE), .NREQ(NREQ)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_num(req_num), .req_data(req_data), .hold(hold),
    .reserve_valid(reserve_valid), .reserve_num(reserve_num),
    .readnum1(readnum1), .readnum2(readnum2), .hazard1(hazard1), .hazard2(hazard2),
    .rf_write(rf_write), .rf_writenum(rf_writenum), .rf_data_in(rf_data_in), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  // Reference model state
  int              m_ptr;
  bit [SIZE-1:0]   m_busy;
  bit              m_wr;
  bit [AW-1:0]     m_num;
  bit [WIDTH-1:0]  m_data;
  int              last_g = -1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int model_grant();
    if (reset || hold) return -1;
    for (int k = 0; k < NREQ; k++) begin
      int i;
      i = (m_ptr + k) % NREQ;
      if (req_valid[i]) return i;
    end
    return -1;
  endfunction

  always @(posedge clk) begin : model
    int g;
    bit [SIZE-1:0] nb;
    if (reset) begin
      m_ptr  = 0;
      m_busy = '0;
      m_wr   = 1'b0;
      m_num  = '0;
      m_data = '0;
      last_g = -1;
    end else begin
      g  = model_grant();
      nb = m_busy;
      if (m_wr) nb[m_num] = 1'b0;
      if (reserve_valid) nb[reserve_num] = 1'b1;
      m_busy = nb;
      last_g = g;
      if (g >= 0) begin
        m_wr   = 1'b1;
        m_num  = req_num[g*AW +: AW];
        m_data = req_data[g*WIDTH +: WIDTH];
        m_ptr  = (g + 1) % NREQ;
      end else begin
        m_wr = 1'b0;
      end
    end
  end

  always @(negedge clk) begin : compare
    int g;
    logic [NREQ-1:0] exp_ready;
    if (chk_en) begin
      g = model_grant();
      exp_ready = '0;
      if (g >= 0) exp_ready[g] = 1'b1;
      check("req_ready", req_ready, exp_ready);
      check("hazard1", hazard1, m_busy[readnum1]);
      check("hazard2", hazard2, m_busy[readnum2]);
      check("rf_write", rf_write, m_wr);
      check("rf_writenum", rf_writenum, m_num);
      check("rf_data_in", rf_data_in, m_data);
      check("busy", busy, m_busy);
    end
  end

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset with requests pending
    reset = 1'b1; hold = 1'b0;
    req_valid = 2'b11;
    req_num  = {3'd2, 3'd1};
    req_data = {16'hB1B1, 16'hA0A0};
    reserve_valid = 1'b1; reserve_num = 3'd4;
    readnum1 = 3'd0; readnum2 = 3'd5;
    @(negedge clk); check("rst_ready0", req_ready, 2'b00);
    cyc; chk_en = 1'b1;
    @(negedge clk);
    check("rst_write", rf_write, 1'b0);
    check("rst_busy", busy, 8'h00);
    check("rst_ready1", req_ready, 2'b00);
    cyc;

    // Round-robin: both valid for 6 cycles
    reset = 1'b0; reserve_valid = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("rr_ready", req_ready, (k % 2) ? 2'b10 : 2'b01);
      if (k > 0) begin
        check("rr_write", rf_write, 1'b1);
        check("rr_data", rf_data_in, ((k - 1) % 2) ? 16'hB1B1 : 16'hA0A0);
      end
      cyc;
    end

    // Single write to reserved r3
    req_valid = 2'b00; reserve_valid = 1'b1; reserve_num = 3'd3; readnum1 = 3'd3;
    @(negedge clk); check("sw_haz_pre", hazard1, 1'b0);
    cyc;
    reserve_valid = 1'b0; req_valid = 2'b10;
    req_num[5:3] = 3'd3; req_data[31:16] = 16'hBEEF;
    @(negedge clk);
    check("sw_haz", hazard1, 1'b1);
    check("sw_ready", req_ready, 2'b10);
    cyc;
    req_valid = 2'b00;
    @(negedge clk);
    check("sw_write", rf_write, 1'b1);
    check("sw_num", rf_writenum, 3'd3);
    check("sw_data", rf_data_in, 16'hBEEF);
    check("sw_haz_hold", hazard1, 1'b1);
    cyc;
    @(negedge clk);
    check("sw_haz_clr", hazard1, 1'b0);
    check("sw_busy3", busy[3], 1'b0);
    cyc;

    // Same-cycle set and clear of r5
    reserve_valid = 1'b1; reserve_num = 3'd5;
    cyc;
    reserve_valid = 1'b0; req_valid = 2'b01;
    req_num[2:0] = 3'd5; req_data[15:0] = 16'h5555;
    @(negedge clk); check("sc_ready", req_ready, 2'b01);
    cyc;
    req_valid = 2'b00; reserve_valid = 1'b1; reserve_num = 3'd5;
    @(negedge clk); check("sc_write", rf_write, 1'b1);
    cyc;
    reserve_valid = 1'b0;
    @(negedge clk); check("sc_busy5", busy[5], 1'b1);
    cyc;

    // Hold with an in-flight write to r5
    req_valid = 2'b01; req_data[15:0] = 16'h6666;
    @(negedge clk); check("hd_pre", req_ready, 2'b01);
    cyc;
    hold = 1'b1; req_valid = 2'b11;
    req_num = {3'd2, 3'd1};
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("hd_ready", req_ready, 2'b00);
      check("hd_write", rf_write, (k == 0) ? 1'b1 : 1'b0);
      check("hd_busy5", busy[5], (k == 0) ? 1'b1 : 1'b0);
      cyc;
    end
    hold = 1'b0;
    @(negedge clk); check("hd_resume", req_ready, 2'b10);
    cyc;

    // Reset mid-operation
    reserve_valid = 1'b1; reserve_num = 3'd2; req_valid = 2'b01;
    req_num[2:0] = 3'd2; req_data[15:0] = 16'h2222;
    @(negedge clk); check("rm_ready", req_ready, 2'b01);
    cyc;
    reserve_valid = 1'b0; req_valid = 2'b00; reset = 1'b1;
    @(negedge clk); check("rm_ready_rst", req_ready, 2'b00);
    cyc;
    reset = 1'b0;
    @(negedge clk);
    check("rm_write", rf_write, 1'b0);
    check("rm_busy", busy, 8'h00);
    cyc;

    // Randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!(req_valid[i] && last_g != i && $urandom_range(9) != 0)) begin
          req_valid[i] = ($urandom_range(2) != 0);
          req_num[i*AW +: AW] = AW'($urandom_range(SIZE - 1));
          req_data[i*WIDTH +: WIDTH] = WIDTH'($urandom);
        end
      end
      hold          = ($urandom_range(9) == 0);
      reserve_valid = ($urandom_range(2) == 0);
      reserve_num   = AW'($urandom_range(SIZE - 1));
      readnum1      = AW'($urandom_range(SIZE - 1));
      readnum2      = AW'($urandom_range(SIZE - 1));
      reset         = ($urandom_range(99) == 0);
      @(negedge clk);
      cyc;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
`default_nettype wire
